rw_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port DATA_WIDTH x 2^ADDR_WIDTH memory between N_PORTS read/write command channels, each fed by its own multisim pull-then-push server pair. It accepts at most one command at a time, performs the access, and routes the response back to the issuing port. It sits in the emulation top between the multisim servers and the shared memory model.

---
 rtl/rw_mem_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/rw_mem_arbiter.sv | 110 +++++++++++
 tb/tb_rw_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_mem_pkg.sv
// rw_mem_pkg
//   Shared types and constants for rw_mem_arbiter.
//   - state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   - RWB_BIT  : bit position of the read/write flag inside a command slice
//   - ADDR_OFS : word offset (in DATA_WIDTH units) of the address field
//   - WDATA_OFS: word offset (in DATA_WIDTH units) of the write-data field
//   - rw_cmd_t : one command slice at the default 64-bit data width
package rw_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned RWB_BIT   = 0;
    localparam int unsigned ADDR_OFS  = 1;
    localparam int unsigned WDATA_OFS = 2;

    localparam int unsigned CMD_WORD_W = 64;

    // Packed so that rwb lands in the low word, matching the bus slice layout.
    typedef struct packed {
        logic [CMD_WORD_W-1:0] wdata;
        logic [CMD_WORD_W-1:0] addr;
        logic [CMD_WORD_W-1:0] rwb;
    } rw_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Rotating-priority search: picks the first asserted request at or above
//   rr_ptr, wrapping around.
//   - req       in  N_PORTS  request vector
//   - rr_ptr    in  IDX_W    index with highest priority this cycle
//   - grant     out N_PORTS  onehot grant (all zero when no request)
//   - grant_idx out IDX_W    index of the granted request
//   - grant_any out 1        at least one request present
module rr_arbiter #(
    parameter int unsigned N_PORTS = 2,
    localparam int unsigned IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int unsigned k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            k = (32'(rr_ptr) + i) % N_PORTS;
            if (!grant_any && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rw_mem_arbiter.sv
// rw_mem_arbiter
//   Round-robin arbiter sharing one single-port memory between N_PORTS
//   read/write command channels. One command in flight at a time; the
//   response is returned on the issuing port only.
//   - clk     in  1                   clock
//   - rst     in  1                   synchronous active-high reset
//   - cmd_vld in  N_PORTS             per-port command valid
//   - cmd_rdy out N_PORTS             per-port command ready (IDLE only)
//   - cmd     in  N_PORTS*3*DATA_WIDTH per-port {wdata, addr, rwb-word}
//   - rsp_vld out N_PORTS             per-port response valid
//   - rsp_rdy in  N_PORTS             per-port response ready
//   - rsp     out N_PORTS*DATA_WIDTH  per-port response data
module rw_mem_arbiter
    import rw_mem_pkg::*;
#(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_PORTS-1:0]                cmd_vld,
    output logic [N_PORTS-1:0]                cmd_rdy,
    input  logic [N_PORTS*3*DATA_WIDTH-1:0]   cmd,
    output logic [N_PORTS-1:0]                rsp_vld,
    input  logic [N_PORTS-1:0]                rsp_rdy,
    output logic [N_PORTS*DATA_WIDTH-1:0]     rsp
);

    localparam int unsigned IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned SLICE_W = 3 * DATA_WIDTH;
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        g_q;
    logic                    rwb_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rsp_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [N_PORTS-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;

    rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_rr (
        .req       (cmd_vld),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            g_q     <= '0;
            rwb_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_rdy equals grant in IDLE, so any grant is a transfer.
                    if (grant_any) begin
                        g_q     <= grant_idx;
                        rwb_q   <= cmd[32'(grant_idx) * SLICE_W + RWB_BIT];
                        addr_q  <= cmd[32'(grant_idx) * SLICE_W + ADDR_OFS * DATA_WIDTH +: ADDR_WIDTH];
                        wdata_q <= cmd[32'(grant_idx) * SLICE_W + WDATA_OFS * DATA_WIDTH +: DATA_WIDTH];
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_q <= rwb_q ? mem[addr_q] : '0;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_rdy[g_q]) begin
                        rr_ptr <= (32'(g_q) == N_PORTS - 1) ? '0 : g_q + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory has no reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && !rwb_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        cmd_rdy = (state == IDLE) ? grant : '0;
        rsp_vld = '0;
        rsp     = '0;
        if (state == RESP) begin
            rsp_vld[g_q]                             = 1'b1;
            rsp[32'(g_q) * DATA_WIDTH +: DATA_WIDTH] = rsp_q;
        end
    end

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// tb_rw_mem_arbiter
//   Randomised and directed stimulus for rw_mem_arbiter, checked every cycle
//   against a transaction-level reference model (array memory, grant pointer,
//   age of the in-flight command).
module tb_rw_mem_arbiter;
    import rw_mem_pkg::*;

    localparam int N     = 2;
    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        cmd_vld;
    logic [N-1:0]        cmd_rdy;
    logic [N*3*DW-1:0]   cmd;
    logic [N-1:0]        rsp_vld;
    logic [N-1:0]        rsp_rdy;
    logic [N*DW-1:0]     rsp;

    always #5 clk = ~clk;

    rw_mem_arbiter #(
        .N_PORTS    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .cmd     (cmd),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp     (rsp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            ptr;
    bit            busy;
    int            age;          // cycles since accept; >=2 means response due
    int            cur_port;
    rw_cmd_t       cur_cmd;
    logic [DW-1:0] exp_rsp;
    logic [DW-1:0] last_rsp [N];
    int            grant_log [$];

    // Stimulus state
    rw_cmd_t       cmd_q [N][$];
    bit            rand_vld;
    bit            rand_rdy;
    int            rdy_hold;
    int            hold_port;

    function automatic logic [191:0] rnd192();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r = {r[159:0], $urandom};
        return r;
    endfunction

    function automatic rw_cmd_t mk(input bit rd, input logic [63:0] a, input logic [63:0] d);
        rw_cmd_t c;
        c.rwb   = {$urandom, $urandom};
        c.rwb[0] = rd;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    function automatic bit pending();
        bit p;
        p = busy;
        for (int i = 0; i < N; i++) if (cmd_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            bit v;
            v = cmd_q[p].size() > 0;
            if (rand_vld && $urandom_range(0, 3) == 0) v = 1'b0;
            cmd_vld[p] = v;
            cmd[p*3*DW +: 3*DW] = v ? cmd_q[p][0] : rnd192();
        end
        if (rdy_hold > 0) begin
            rsp_rdy = '1;
            rsp_rdy[hold_port] = 1'b0;
        end else if (rand_rdy) begin
            rsp_rdy = N'($urandom);
        end else begin
            rsp_rdy = '1;
        end
    endtask

    // Compare outputs mid-cycle, then advance the model across the next edge.
    task automatic tick();
        logic [N-1:0]    e_rdy;
        logic [N-1:0]    e_vld;
        logic [N*DW-1:0] e_rsp;
        int              g;
        @(negedge clk);
        e_rdy = '0;
        e_vld = '0;
        e_rsp = '0;
        g     = -1;
        if (!busy) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = (ptr + i) % N;
                if (g < 0 && cmd_vld[p]) g = p;
            end
            if (g >= 0) e_rdy[g] = 1'b1;
        end else if (age >= 2) begin
            e_vld[cur_port] = 1'b1;
            e_rsp[cur_port*DW +: DW] = exp_rsp;
        end
        check("cmd_rdy", 128'(cmd_rdy), 128'(e_rdy));
        check("rsp_vld", 128'(rsp_vld), 128'(e_vld));
        check("rsp", 128'(rsp), 128'(e_rsp));

        if (rst) begin
            busy = 1'b0;
            ptr  = 0;
        end else if (!busy) begin
            if (g >= 0) begin
                busy     = 1'b1;
                age      = 1;
                cur_port = g;
                cur_cmd  = cmd_q[g][0];
                void'(cmd_q[g].pop_front());
                grant_log.push_back(g);
            end
        end else if (age == 1) begin
            if (cur_cmd.rwb[0]) begin
                exp_rsp = ref_mem[cur_cmd.addr % DEPTH];
            end else begin
                ref_mem[cur_cmd.addr % DEPTH] = cur_cmd.wdata;
                exp_rsp = '0;
            end
            age = 2;
        end else if (rsp_rdy[cur_port]) begin
            last_rsp[cur_port] = exp_rsp;
            ptr  = (cur_port + 1) % N;
            busy = 1'b0;
        end else begin
            age++;
        end
        if (rdy_hold > 0) rdy_hold--;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            drive();
            tick();
            n++;
        end
        check("timeout", 128'(pending()), 128'(0));
    endtask

    // Step until the model has a command in flight of at least the given age.
    task automatic run_until_age(input int want);
        int n;
        n = 0;
        while (!(busy && age >= want) && n < 20) begin
            drive();
            tick();
            n++;
        end
        check("reach_age", 128'(busy && age >= want), 128'(1));
    endtask

    localparam logic [63:0] K33  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] OLD  = 64'hAAAA_5555_0000_0044;
    localparam logic [63:0] NEWV = 64'h1111_2222_3333_4444;

    initial begin
        rst       = 1'b1;
        cmd_vld   = '0;
        cmd       = '0;
        rsp_rdy   = '0;
        ptr       = 0;
        busy      = 1'b0;
        age       = 0;
        cur_port  = 0;
        exp_rsp   = '0;
        rand_vld  = 1'b0;
        rand_rdy  = 1'b0;
        rdy_hold  = 0;
        hold_port = 0;
        for (int p = 0; p < N; p++) last_rsp[p] = '0;

        repeat (2) @(posedge clk);
        #1;
        tick();                                  // reset-state outputs
        rst = 1'b0;

        // Populate every word so later reads have defined expectations.
        for (int a = 0; a < DEPTH; a++) cmd_q[0].push_back(mk(1'b0, 64'(a), {$urandom, $urandom}));
        run(3000);

        // Single port write then read.
        cmd_q[0].push_back(mk(1'b0, 64'h05, 64'hDEADBEEF_00000001));
        cmd_q[0].push_back(mk(1'b1, 64'h05, 64'h0));
        run(50);
        check("rd_05", 128'(last_rsp[0]), 128'(64'hDEADBEEF_00000001));

        // Upper address bits alias onto the same word.
        cmd_q[1].push_back(mk(1'b0, 64'h105, 64'h11));
        cmd_q[1].push_back(mk(1'b1, 64'h05, 64'h0));
        run(50);
        check("alias", 128'(last_rsp[1]), 128'(64'h11));

        // Both ports continuously valid: grants alternate.
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            cmd_q[0].push_back(mk(1'($urandom), 64'($urandom), {$urandom, $urandom}));
            cmd_q[1].push_back(mk(1'($urandom), 64'($urandom), {$urandom, $urandom}));
        end
        run(100);
        check("alt_cnt", 128'(grant_log.size()), 128'(8));
        for (int i = 0; i < grant_log.size(); i++) check("alt", 128'(grant_log[i]), 128'(i % 2));

        // Back-pressure on port 0 blocks port 1.
        grant_log.delete();
        hold_port = 0;
        rdy_hold  = 12;
        cmd_q[0].push_back(mk(1'b1, 64'h05, 64'h0));
        cmd_q[1].push_back(mk(1'b1, 64'h06, 64'h0));
        run(100);
        check("bp_cnt", 128'(grant_log.size()), 128'(2));
        if (grant_log.size() == 2) begin
            check("bp_g0", 128'(grant_log[0]), 128'(0));
            check("bp_g1", 128'(grant_log[1]), 128'(1));
        end

        // Reset while a read response is pending.
        cmd_q[0].push_back(mk(1'b0, 64'h33, K33));
        run(50);
        hold_port = 0;
        rdy_hold  = 100;
        cmd_q[0].push_back(mk(1'b1, 64'h33, 64'h0));
        run_until_age(2);
        rst = 1'b1;
        drive();
        tick();
        rst      = 1'b0;
        rdy_hold = 0;
        grant_log.delete();
        cmd_q[1].push_back(mk(1'b1, 64'h33, 64'h0));
        cmd_q[0].push_back(mk(1'b1, 64'h33, 64'h0));
        run(50);
        if (grant_log.size() > 0) check("rst_ptr", 128'(grant_log[0]), 128'(0));
        else check("rst_ptr_cnt", 128'(grant_log.size()), 128'(2));
        check("rst_mem0", 128'(last_rsp[0]), 128'(K33));
        check("rst_mem1", 128'(last_rsp[1]), 128'(K33));

        // Reset coinciding with a write in ACCESS suppresses the write.
        cmd_q[0].push_back(mk(1'b0, 64'h44, OLD));
        run(50);
        cmd_q[0].push_back(mk(1'b0, 64'h44, NEWV));
        run_until_age(1);
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        cmd_q[0].push_back(mk(1'b1, 64'h44, 64'h0));
        run(50);
        check("rst_wr", 128'(last_rsp[0]), 128'(OLD));

        // Random traffic with gated valids and random response ready.
        rand_vld = 1'b1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            for (int p = 0; p < N; p++) begin
                cmd_q[p].push_back(mk(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}));
            end
        end
        run(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
